// File: rtl/uart_avm_arbiter.sv
// Two-master round-robin arbiter in front of the UART Avalon-MM slave port.
// One transfer per grant, with a waitrequest-stall watchdog that revokes a stuck grant.
module uart_avm_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              avm_clk,
  input  logic              avm_rst,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_M0   = 2'd1,
    S_M1   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;
  logic              req0, req1;
  logic              busy, own_id, own_req, other_req;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  assign m0_readdata = avm_readdata;
  assign m1_readdata = avm_readdata;
  assign grant       = {state_q == S_M1, state_q == S_M0};
  assign timeout_err = tmo_q;

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    tmo_d          = 1'b0;
    busy           = 1'b0;
    own_id         = 1'b0;
    own_req        = 1'b0;
    other_req      = 1'b0;
    avm_address    = '0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_writedata  = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;

    case (state_q)
      S_IDLE: begin
        // On a tie the master that was not served last wins.
        if (req0 && (!req1 || last_q)) begin
          state_d = S_M0;
        end else if (req1) begin
          state_d = S_M1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_M0: begin
        busy           = 1'b1;
        own_id         = 1'b0;
        own_req        = req0;
        other_req      = req1;
        avm_address    = m0_address;
        avm_read       = m0_read;
        avm_write      = m0_write;
        avm_writedata  = m0_writedata;
        m0_waitrequest = avm_waitrequest;
      end
      S_M1: begin
        busy           = 1'b1;
        own_id         = 1'b1;
        own_req        = req1;
        other_req      = req0;
        avm_address    = m1_address;
        avm_read       = m1_read;
        avm_write      = m1_write;
        avm_writedata  = m1_writedata;
        m1_waitrequest = avm_waitrequest;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Granted-state exits: completion, abandonment, or watchdog revoke.
    if (busy) begin
      if (own_req && !avm_waitrequest) begin
        last_d = own_id;
        if (other_req) begin
          state_d = own_id ? S_M0 : S_M1;
        end else begin
          state_d = S_IDLE;
        end
      end else if (!own_req) begin
        state_d = S_IDLE;
      end else if (WD_EN && (cnt_q >= CNT_LAST)) begin
        state_d = S_IDLE;
        tmo_d   = 1'b1;
        last_d  = own_id;
      end else begin
        state_d = state_q;
      end
    end else begin
      last_d = last_q;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (busy && avm_waitrequest && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

endmodule

// File: tb/tb_uart_avm_arbiter.sv
// Directed bench for uart_avm_arbiter: stimulus pushes expected slave transfers and
// watchdog events into a queue; a negedge monitor pops and compares them.
module tb_uart_avm_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          avm_clk = 1'b0;
  logic          avm_rst;
  logic [AW-1:0] m0_address, m1_address, avm_address;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
  logic          m0_waitrequest, m1_waitrequest;
  logic          avm_read, avm_write, avm_waitrequest;
  logic [DW-1:0] avm_writedata, avm_readdata;
  logic [1:0]    grant;
  logic          timeout_err;

  typedef struct packed {
    logic          tmo;
    logic [1:0]    gnt;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          own_wait;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  uart_avm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .avm_clk(avm_clk), .avm_rst(avm_rst),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 avm_clk = ~avm_clk;

  task automatic step();
    @(posedge avm_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_xfer(input logic [1:0] g, input logic [AW-1:0] a, input logic w,
                           input logic [DW-1:0] d);
    ev_t e;
    e          = '0;
    e.gnt      = g;
    e.addr     = a;
    e.wr       = w;
    e.wdata    = w ? d : '0;
    e.rdata    = w ? '0 : d;
    exp_q.push_back(e);
  endtask

  task automatic push_tmo();
    ev_t e;
    e     = '0;
    e.tmo = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: every slave Done or watchdog pulse must match the head of the queue.
  always @(negedge avm_clk) begin
    ev_t o, e;
    if (!avm_rst && (timeout_err || ((avm_read || avm_write) && !avm_waitrequest))) begin
      o = '0;
      if (timeout_err) begin
        o.tmo = 1'b1;
        o.gnt = grant;
      end else begin
        o.gnt      = grant;
        o.addr     = avm_address;
        o.wr       = avm_write;
        o.wdata    = avm_write ? avm_writedata : '0;
        o.rdata    = avm_write ? '0 : ((grant == 2'b10) ? m1_readdata : m0_readdata);
        o.own_wait = (grant == 2'b10) ? m1_waitrequest : m0_waitrequest;
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got tmo=%0d gnt=%b addr=%0h wr=%0d wdata=%0h expected no event",
                 o.tmo, o.gnt, o.addr, o.wr, o.wdata);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL sb_event: got tmo=%0d gnt=%b addr=%0h wr=%0d wdata=%0h rdata=%0h wait=%0d expected tmo=%0d gnt=%b addr=%0h wr=%0d wdata=%0h rdata=%0h wait=%0d",
                   o.tmo, o.gnt, o.addr, o.wr, o.wdata, o.rdata, o.own_wait,
                   e.tmo, e.gnt, e.addr, e.wr, e.wdata, e.rdata, e.own_wait);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    avm_rst = 1'b1;
    m0_address = 5'd8; m0_read = 1'b1; m0_write = 1'b0; m0_writedata = 32'h0;
    m1_address = 5'd0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = 32'h0;
    avm_waitrequest = 1'b1; avm_readdata = 32'h0;

    // Reset held with m0 requesting.
    for (int i = 0; i < 3; i++) begin
      @(negedge avm_clk);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_avm_read", 32'(avm_read), 32'h0);
      chk("rst_m0_wait", 32'(m0_waitrequest), 32'h1);
      step();
    end

    // Single read of STATUS with two stall cycles.
    avm_rst = 1'b0;
    @(negedge avm_clk);
    chk("rd_latency", 32'(grant), 32'h0);
    step();
    @(negedge avm_clk);
    chk("rd_grant", 32'(grant), 32'h1);
    chk("rd_stall_wait", 32'(m0_waitrequest), 32'h1);
    step();
    step();
    avm_waitrequest = 1'b0; avm_readdata = 32'h80;
    push_xfer(2'b01, 5'd8, 1'b0, 32'h80);
    step();
    m0_read = 1'b0; avm_waitrequest = 1'b1;
    @(negedge avm_clk);
    chk("rd_release", 32'(grant), 32'h0);

    // Tie after reset, then sustained contention with a zero-wait slave.
    step();
    avm_rst = 1'b1;
    step();
    avm_rst = 1'b0;
    m0_read = 1'b1; m0_address = 5'd8;
    m1_write = 1'b1; m1_address = 5'd4; m1_writedata = 32'h5A;
    avm_waitrequest = 1'b0; avm_readdata = 32'h11;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push_xfer(2'b01, 5'd8, 1'b0, 32'h11);
      else            push_xfer(2'b10, 5'd4, 1'b1, 32'h5A);
    end
    @(negedge avm_clk);
    chk("tie_idle", 32'(grant), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      step();
      @(negedge avm_clk);
      chk("rr_grant", 32'(grant), (k % 2 == 1) ? 32'h1 : 32'h2);
    end
    step();
    m0_read = 1'b0; m1_write = 1'b0;
    step();
    @(negedge avm_clk);
    chk("rr_release", 32'(grant), 32'h0);

    // Watchdog: m1 write stuck on waitrequest while m0 waits.
    step();
    m1_write = 1'b1; m1_address = 5'd4; m1_writedata = 32'h77;
    avm_waitrequest = 1'b1;
    push_tmo();
    push_xfer(2'b01, 5'd0, 1'b0, 32'h3C);
    push_xfer(2'b10, 5'd4, 1'b1, 32'h77);
    step();
    m0_read = 1'b1; m0_address = 5'd0;
    @(negedge avm_clk);
    chk("wd_grant_m1", 32'(grant), 32'h2);
    for (int k = 0; k < 7; k++) step();
    @(negedge avm_clk);
    chk("wd_still_m1", 32'(grant), 32'h2);
    chk("wd_no_pulse_yet", 32'(timeout_err), 32'h0);
    step();
    avm_waitrequest = 1'b0; avm_readdata = 32'h3C;
    @(negedge avm_clk);
    chk("wd_pulse", 32'(timeout_err), 32'h1);
    chk("wd_grant_idle", 32'(grant), 32'h0);
    chk("wd_m1_wait", 32'(m1_waitrequest), 32'h1);
    step();
    @(negedge avm_clk);
    chk("wd_m0_next", 32'(grant), 32'h1);
    chk("wd_pulse_once", 32'(timeout_err), 32'h0);
    step();
    m0_read = 1'b0;
    @(negedge avm_clk);
    chk("wd_m1_retry", 32'(grant), 32'h2);
    step();
    m1_write = 1'b0;
    @(negedge avm_clk);
    chk("wd_release", 32'(grant), 32'h0);

    // Abandoned stalled write.
    step();
    m1_write = 1'b1; m1_address = 5'd4; m1_writedata = 32'h99;
    avm_waitrequest = 1'b1;
    step();
    @(negedge avm_clk);
    chk("ab_grant", 32'(grant), 32'h2);
    step();
    m1_write = 1'b0;
    step();
    @(negedge avm_clk);
    chk("ab_idle", 32'(grant), 32'h0);
    chk("ab_no_tmo", 32'(timeout_err), 32'h0);

    // Reset in the middle of an m0 read, then re-issue.
    step();
    m0_read = 1'b1; m0_address = 5'd8;
    step();
    @(negedge avm_clk);
    chk("mr_read_out", 32'(avm_read), 32'h1);
    avm_rst = 1'b1;
    step();
    @(negedge avm_clk);
    chk("mr_read_drop", 32'(avm_read), 32'h0);
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_m0_wait", 32'(m0_waitrequest), 32'h1);
    step();
    avm_rst = 1'b0; avm_waitrequest = 1'b0; avm_readdata = 32'h42;
    push_xfer(2'b01, 5'd8, 1'b0, 32'h42);
    step();
    @(negedge avm_clk);
    chk("mr_regrant", 32'(grant), 32'h1);
    step();
    m0_read = 1'b0;
    step();
    @(negedge avm_clk);
    chk("mr_release", 32'(grant), 32'h0);

    step();
    step();
    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
